adder_tree_scheduler: RTL and testbench

- Round-robin arbiter and sequencer sharing one 64-input FP32 reduction tree (start/finish-handshaked adder tree) among NREQ requesters.
- Captures the granted requester's 64-word vector and pulses the tree start.
- Waits for the tree finish, then returns the 32-bit sum tagged with the requester ID.
- Sits between the matrix-vector engines and the single shared adder tree instance.

---
 rtl/adder_tree_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_adder_tree_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_scheduler.sv
// adder_tree_scheduler: round-robin arbiter/sequencer in front of one shared
// 64-input FP32 reduction tree. Grants one requester at a time, captures its
// vector, pulses tree_start, waits for tree_finish and returns the sum tagged
// with the requester ID.
// Optional watchdog: define ADDER_SCHED_TIMEOUT_EN to bound the WAIT state
// at TIMEOUT_CYCLES and return a qNaN with err=1 on expiry.
module adder_tree_scheduler #(
    parameter int NI             = 64,
    parameter int NREQ           = 4,
    parameter int IDW            = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*NI*32-1:0]  req_vec,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic                   tree_start,
    output logic [NI*32-1:0]       tree_inputs,
    input  logic                   tree_finish,
    input  logic [31:0]            tree_sum,
    output logic [NREQ-1:0]        done,
    output logic [31:0]            result,
    output logic [IDW-1:0]         result_id,
    output logic                   err,
    output logic [15:0]            last_latency
);

    localparam int VW = NI * 32;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [IDW-1:0]    ptr_reg, ptr_next;
    logic [IDW-1:0]    gid_reg, gid_next;
    logic [VW-1:0]     tree_inputs_reg, tree_inputs_next;
    logic [NREQ-1:0]   grant_reg, grant_next;
    logic              tree_start_reg, tree_start_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic [31:0]       result_reg, result_next;
    logic [IDW-1:0]    result_id_reg, result_id_next;
    logic [15:0]       lat_reg, lat_next;
    logic [15:0]       last_latency_reg, last_latency_next;
    logic [15:0]       lat_inc;

    // Per-requester view of the flat vector bus
    logic [VW-1:0]     vec_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_split
            assign vec_arr[gi] = req_vec[(gi+1)*VW-1 -: VW];
        end
    endgenerate

    // Round-robin pick: first set request bit at or after the pointer, wrapping
    logic              found;
    logic [IDW-1:0]    pick;
    logic [IDW-1:0]    idx_l;
    int                idx;

    // Scan requests starting from the pointer
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        idx_l = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_l = IDW'(idx);
            if (!found && req[idx_l]) begin
                found = 1'b1;
                pick  = idx_l;
            end
        end
    end

    // WAIT-cycle counter saturates instead of wrapping
    assign lat_inc = (lat_reg == 16'hFFFF) ? lat_reg : lat_reg + 16'd1;

`ifdef ADDER_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic err_reg, err_next;
`else
    // Watchdog limit has no meaning without the timeout feature
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_next        = state_reg;
        ptr_next          = ptr_reg;
        gid_next          = gid_reg;
        tree_inputs_next  = tree_inputs_reg;
        grant_next        = '0;
        tree_start_next   = 1'b0;
        done_next         = '0;
        result_next       = result_reg;
        result_id_next    = result_id_reg;
        lat_next          = lat_reg;
        last_latency_next = last_latency_reg;
`ifdef ADDER_SCHED_TIMEOUT_EN
        err_next          = err_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (found) begin
                    grant_next       = ONE_HOT0 << pick;
                    tree_inputs_next = vec_arr[pick];
                    gid_next         = pick;
                    ptr_next         = (pick == LAST_ID) ? '0 : pick + 1'b1;
                    state_next       = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tree_start_next = 1'b1;
                lat_next        = '0;
                state_next      = S_WAIT;
            end
            S_WAIT: begin
                lat_next = lat_inc;
                if (tree_finish) begin
                    result_next       = tree_sum;
                    result_id_next    = gid_reg;
                    last_latency_next = lat_inc;
                    done_next         = ONE_HOT0 << gid_reg;
`ifdef ADDER_SCHED_TIMEOUT_EN
                    err_next          = 1'b0;
`endif
                    state_next        = S_DONE;
                end
`ifdef ADDER_SCHED_TIMEOUT_EN
                else if (lat_inc == TO_LIMIT) begin
                    // Give up: report qNaN and re-arm the tree's finish latch
                    result_next       = 32'h7FC00000;
                    result_id_next    = gid_reg;
                    last_latency_next = TO_LIMIT;
                    done_next         = ONE_HOT0 << gid_reg;
                    err_next          = 1'b1;
                    tree_start_next   = 1'b1;
                    state_next        = S_DONE;
                end
`endif
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            ptr_reg          <= '0;
            gid_reg          <= '0;
            tree_inputs_reg  <= '0;
            grant_reg        <= '0;
            tree_start_reg   <= 1'b0;
            done_reg         <= '0;
            result_reg       <= '0;
            result_id_reg    <= '0;
            lat_reg          <= '0;
            last_latency_reg <= '0;
        end else begin
            state_reg        <= state_next;
            ptr_reg          <= ptr_next;
            gid_reg          <= gid_next;
            tree_inputs_reg  <= tree_inputs_next;
            grant_reg        <= grant_next;
            tree_start_reg   <= tree_start_next;
            done_reg         <= done_next;
            result_reg       <= result_next;
            result_id_reg    <= result_id_next;
            lat_reg          <= lat_next;
            last_latency_reg <= last_latency_next;
        end
    end

`ifdef ADDER_SCHED_TIMEOUT_EN
    // Timeout flag register, updated on every completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign grant        = grant_reg;
    assign busy         = (state_reg != S_IDLE);
    assign tree_start   = tree_start_reg;
    assign tree_inputs  = tree_inputs_reg;
    assign done         = done_reg;
    assign result       = result_reg;
    assign result_id    = result_id_reg;
    assign last_latency = last_latency_reg;

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Scoreboard bench for adder_tree_scheduler with a stub reduction tree.
// Timeout scenario runs only when ADDER_SCHED_TIMEOUT_EN is defined.
module tb_adder_tree_scheduler;

    localparam int NI   = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 20;
    localparam int VW   = NI * 32;
    // Stub tree raises finish in the 4th WAIT cycle after it sees tree_start
    localparam int LAT_AUTO = 4;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*VW-1:0]    req_vec;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  tree_start;
    logic [VW-1:0]         tree_inputs;
    logic                  tree_finish;
    logic [31:0]           tree_sum;
    logic [NREQ-1:0]       done;
    logic [31:0]           result;
    logic [IDW-1:0]        result_id;
    logic                  err;
    logic [15:0]           last_latency;

    adder_tree_scheduler #(
        .NI(NI), .NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_vec(req_vec),
        .grant(grant), .busy(busy), .tree_start(tree_start),
        .tree_inputs(tree_inputs), .tree_finish(tree_finish),
        .tree_sum(tree_sum), .done(done), .result(result),
        .result_id(result_id), .err(err), .last_latency(last_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub tree: automatic responder or manual drive from the main sequence
    logic        auto_tree, auto_fin, man_fin;
    logic [31:0] auto_sum, man_sum;
    assign tree_finish = auto_fin | man_fin;
    assign tree_sum    = auto_tree ? auto_sum : man_sum;

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        err;
        logic [15:0] lat;
    } exp_t;

    exp_t sq[$];
    int   gq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   start_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word k+1.0 for requester k, and the 64-word sum of it
    function automatic logic [31:0] word_of(input int k);
        case (k)
            0: word_of = 32'h3F800000;
            1: word_of = 32'h40000000;
            2: word_of = 32'h40400000;
            default: word_of = 32'h40800000;
        endcase
    endfunction

    function automatic logic [31:0] sum_of(input int k);
        case (k)
            0: sum_of = 32'h42800000;
            1: sum_of = 32'h43000000;
            2: sum_of = 32'h43400000;
            default: sum_of = 32'h43800000;
        endcase
    endfunction

    function automatic logic [31:0] tree_of_word(input logic [31:0] w);
        tree_of_word = 32'hDEADBEEF;
        for (int k = 0; k < NREQ; k++) begin
            if (word_of(k) == w) tree_of_word = sum_of(k);
        end
    endfunction

    task automatic set_vec(input int r);
        for (int w = 0; w < NI; w++) begin
            req_vec[r*VW + w*32 +: 32] = word_of(r);
        end
    endtask

    task automatic push_op(input int r);
        exp_t e;
        e.id = r; e.sum = sum_of(r); e.err = 1'b0; e.lat = 16'(LAT_AUTO);
        gq.push_back(r);
        sq.push_back(e);
    endtask

    task automatic wait_grants(input int n, input string tag);
        int cnt = 0;
        for (int i = 0; i < 400 && cnt < n; i++) begin
            @(negedge clk);
            if (grant != 0) cnt++;
        end
        check_val(tag, cnt, n);
    endtask

    task automatic wait_drain(input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (sq.size() == 0 && gq.size() == 0 && !busy) ok = 1'b1;
        end
        check_val(tag, ok, 1);
    endtask

    task automatic check_zero(input string p);
        check_val({p, "_grant"}, grant, 0);
        check_val({p, "_busy"}, busy, 0);
        check_val({p, "_start"}, tree_start, 0);
        check_val({p, "_done"}, done, 0);
        check_val({p, "_result"}, result, 0);
        check_val({p, "_rid"}, result_id, 0);
        check_val({p, "_err"}, err, 0);
        check_val({p, "_lat"}, last_latency, 0);
        check_val({p, "_inputs"}, |tree_inputs, 0);
    endtask

    task automatic do_reset(input string p);
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        check_zero(p);
        rst_n = 1'b1;
    endtask

    // Monitor: grant order and done results against the scoreboard
    int   mon_g;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (tree_start) start_cnt++;
            if (grant != 0) begin
                if (gq.size() == 0) begin
                    check_val("grant_unexpected", grant, 0);
                end else begin
                    mon_g = gq.pop_front();
                    check_val("grant", grant, NREQ'(1) << mon_g);
                end
            end
            if (done != 0) begin
                if (sq.size() == 0) begin
                    check_val("done_unexpected", done, 0);
                end else begin
                    mon_e = sq.pop_front();
                    $display("done id=%0d result=%h err=%b lat=%0d", result_id, result, err, last_latency);
                    check_val("done_onehot", done, NREQ'(1) << mon_e.id);
                    check_val("result", result, mon_e.sum);
                    check_val("result_id", result_id, mon_e.id);
                    check_val("err", err, mon_e.err);
                    check_val("last_latency", last_latency, mon_e.lat);
                end
            end
        end
    end

    // Automatic stub tree: answers each start with the sum of the captured words
    int mism;
    initial begin
        auto_fin = 1'b0;
        auto_sum = '0;
        forever begin
            @(negedge clk);
            if (auto_tree && tree_start && rst_n) begin
                mism = 0;
                for (int w = 1; w < NI; w++) begin
                    if (tree_inputs[w*32 +: 32] !== tree_inputs[31:0]) mism++;
                end
                check_val("capture_uniform", mism, 0);
                auto_sum = tree_of_word(tree_inputs[31:0]);
                repeat (LAT_AUTO - 1) @(negedge clk);
                auto_fin = 1'b1;
                @(negedge clk);
                auto_fin = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int base;
    logic seen;
    initial begin
        rst_n = 1'b0; req = '0; req_vec = '0;
        auto_tree = 1'b1; man_fin = 1'b0; man_sum = '0;
        for (int r = 0; r < NREQ; r++) set_vec(r);
        do_reset("reset");

        // Single op from requester 0, grant one cycle after req
        base = start_cnt;
        push_op(0);
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        check_val("t1_grant_latency", grant, 4'b0001);
        req = '0;
        wait_drain("t1_drain");
        check_val("t1_start_pulses", start_cnt - base, 1);

        // All four requesting continuously from pointer 0
        do_reset("reset2");
        base = start_cnt;
        push_op(0); push_op(1); push_op(2); push_op(3); push_op(0);
        @(negedge clk);
        req = 4'b1111;
        wait_grants(5, "t2_grants");
        req = '0;
        wait_drain("t2_drain");
        check_val("t2_start_pulses", start_cnt - base, 5);

        // Serve 1 so the pointer sits at 2, then 0 and 1 must wrap in order
        push_op(1);
        req = 4'b0010;
        wait_grants(1, "t3a_grants");
        req = '0;
        wait_drain("t3a_drain");
        push_op(0); push_op(1);
        req = 4'b0011;
        wait_grants(2, "t3b_grants");
        req = '0;
        wait_drain("t3b_drain");

        // Finish during IDLE and LAUNCH is ignored; finish in WAIT completes
        auto_tree = 1'b0;
        man_sum   = sum_of(0);
        man_fin   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_val("t4_idle_done", done, 0);
            check_val("t4_idle_busy", busy, 0);
        end
        push_op(0);
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        check_val("t4_launch_busy", busy, 1);
        @(negedge clk);
        man_fin = 1'b0;
        check_val("t4_start", tree_start, 1);
        check_val("t4_launch_done", done, 0);
        for (int i = 0; i < LAT_AUTO - 1; i++) begin
            @(negedge clk);
            check_val("t4_wait_busy", busy, 1);
            check_val("t4_wait_done", done, 0);
        end
        man_fin = 1'b1;
        @(negedge clk);
        man_fin = 1'b0;
        wait_drain("t4_drain");

        // Reset in WAIT, then a stale finish must be ignored
        gq.push_back(2);
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("t5_midreset");
        rst_n   = 1'b1;
        man_sum = 32'h12345678;
        man_fin = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_val("t5_stale_done", done, 0);
            check_val("t5_stale_busy", busy, 0);
        end
        man_fin   = 1'b0;
        auto_tree = 1'b1;
        push_op(2);
        req = 4'b0100;
        wait_grants(1, "t5_grants");
        req = '0;
        wait_drain("t5_drain");

`ifdef ADDER_SCHED_TIMEOUT_EN
        // Tree never finishes: watchdog answers with qNaN and re-arms the tree
        begin
            exp_t e;
            auto_tree = 1'b0;
            e.id = 3; e.sum = 32'h7FC00000; e.err = 1'b1; e.lat = 16'(TO);
            gq.push_back(3);
            sq.push_back(e);
            base = start_cnt;
            req = 4'b1000;
            wait_grants(1, "t6_grants");
            req = '0;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                if (done != 0) seen = 1'b1;
            end
            check_val("t6_done_seen", seen, 1);
            check_val("t6_rearm_start", tree_start, 1);
            man_sum = 32'h11111111;
            man_fin = 1'b1;
            repeat (2) begin
                @(negedge clk);
                check_val("t6_late_done", done, 0);
                check_val("t6_late_busy", busy, 0);
            end
            man_fin = 1'b0;
            check_val("t6_start_pulses", start_cnt - base, 2);
            check_val("t6_result_held", result, 32'h7FC00000);
            wait_drain("t6_drain");
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
